duck_sprite_indexer: RTL and testbench

Per-pixel stage directly upstream of the 16-entry duck palette lookup. It takes the VGA draw coordinates and the duck's position and state events. It produces the 4-bit palette index for the current pixel, plus a sprite-coverage flag for the colour mux. It owns the duck animation/death state machine and the 44x44 sprite-sheet ROM read pipeline.

---
 rtl/duck_pkg.sv | 25 ++
 rtl/duck_sprite_rom.sv | 23 ++
 rtl/duck_sprite_indexer.sv | 182 ++++++++++++++++++
 tb/tb_duck_sprite_indexer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// Shared duck sprite types and sheet geometry; no logic, no latency.
package duck_pkg;

    localparam int SPR_W      = 44;
    localparam int SPR_H      = 44;
    localparam int N_FLY      = 3;
    localparam int FRAME_HIT  = N_FLY;
    localparam int FRAME_FALL = N_FLY + 1;
    localparam int N_FRAMES   = N_FLY + 2;
    localparam int ROM_AW     = 14;
    localparam int ROM_DEPTH  = N_FRAMES * SPR_W * SPR_H;

    typedef enum logic [1:0] {
        ST_GONE = 2'd0,
        ST_FLY  = 2'd1,
        ST_HIT  = 2'd2,
        ST_FALL = 2'd3
    } duck_state_t;

    // Sheet contents: a fixed texel pattern over the linear sheet address.
    function automatic logic [3:0] sheet_texel(input logic [ROM_AW-1:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ {2'b00, a[13:12]};
    endfunction

endpackage

// File: rtl/duck_sprite_rom.sv
// Sprite-sheet ROM, 4-bit x 9680, synchronous read: 1-cycle latency, no backpressure.
module duck_sprite_rom
    import duck_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ROM_AW-1:0] i_addr,
    output logic [3:0]        o_q
);

    logic [3:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= 4'd0;
        end else begin
            r_q <= (i_addr < ROM_AW'(ROM_DEPTH)) ? sheet_texel(i_addr) : 4'd0;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/duck_sprite_indexer.sv
// Duck FSM plus sprite pixel indexer: index/sprite_on 2 cycles after DrawX/DrawY, no backpressure.
// Optional DUCK_MIRROR_EN flips the sheet horizontally while flying left.
module duck_sprite_indexer
    import duck_pkg::*;
#(
    parameter int ANIM_DIV   = 8,
    parameter int HIT_FRAMES = 30,
    parameter int FALL_STEP  = 2,
    parameter int SCREEN_H   = 480
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] DuckX,
    input  logic [9:0] DuckY,
    input  logic       spawn,
    input  logic       shot,
    input  logic       dir_left,
    output logic [3:0] index,
    output logic       sprite_on,
    output logic [1:0] duck_state,
    output logic       duck_done
);

    duck_state_t r_state, w_state_nx;
    logic [2:0]  r_anim_frame, w_anim_frame_nx;
    logic [7:0]  r_anim_cnt, w_anim_cnt_nx;
    logic [7:0]  r_hit_cnt, w_hit_cnt_nx;
    logic [9:0]  r_fall_off, w_fall_off_nx;
    logic        r_done, w_done_nx;

    logic [10:0] w_ytop;
    logic        w_fall_end;

    assign w_ytop     = {1'b0, DuckY} + {1'b0, r_fall_off};
    assign w_fall_end = (w_ytop >= 11'(SCREEN_H));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_GONE;
            r_anim_frame <= 3'd0;
            r_anim_cnt   <= 8'd0;
            r_hit_cnt    <= 8'd0;
            r_fall_off   <= 10'd0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_anim_frame <= w_anim_frame_nx;
            r_anim_cnt   <= w_anim_cnt_nx;
            r_hit_cnt    <= w_hit_cnt_nx;
            r_fall_off   <= w_fall_off_nx;
            r_done       <= w_done_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_anim_frame_nx = r_anim_frame;
        w_anim_cnt_nx   = r_anim_cnt;
        w_hit_cnt_nx    = r_hit_cnt;
        w_fall_off_nx   = r_fall_off;
        w_done_nx       = 1'b0;
        case (r_state)
            ST_GONE: begin
                if (spawn) begin
                    w_state_nx      = ST_FLY;
                    w_fall_off_nx   = 10'd0;
                    w_anim_frame_nx = 3'd0;
                    w_anim_cnt_nx   = 8'd0;
                end
            end
            ST_FLY: begin
                if (shot) begin
                    w_state_nx   = ST_HIT;
                    w_hit_cnt_nx = 8'd0;
                end else if (frame_start) begin
                    if (r_anim_cnt == 8'(ANIM_DIV - 1)) begin
                        w_anim_cnt_nx   = 8'd0;
                        w_anim_frame_nx = (r_anim_frame == 3'(N_FLY - 1)) ? 3'd0 : r_anim_frame + 3'd1;
                    end else begin
                        w_anim_cnt_nx = r_anim_cnt + 8'd1;
                    end
                end
            end
            ST_HIT: begin
                if (frame_start) begin
                    if (r_hit_cnt == 8'(HIT_FRAMES - 1)) begin
                        w_state_nx = ST_FALL;
                    end else begin
                        w_hit_cnt_nx = r_hit_cnt + 8'd1;
                    end
                end
            end
            ST_FALL: begin
                if (w_fall_end) begin
                    w_state_nx = ST_GONE;
                    w_done_nx  = 1'b1;
                end else if (frame_start) begin
                    w_fall_off_nx = r_fall_off + 10'(FALL_STEP);
                end
            end
            default: w_state_nx = ST_GONE;
        endcase
    end

    // Stage 0: sprite-relative coordinates, bounds check and sheet address.
    logic [10:0]       w_rx, w_ry;
    logic              w_inbox;
    logic [2:0]        w_frame;
    logic [5:0]        w_col;
    logic [ROM_AW-1:0] w_addr;

    assign w_rx    = {1'b0, DrawX} - {1'b0, DuckX};
    assign w_ry    = {1'b0, DrawY} - w_ytop;
    assign w_inbox = (r_state != ST_GONE)
                   && !w_rx[10] && (w_rx < 11'(SPR_W))
                   && !w_ry[10] && (w_ry < 11'(SPR_H));

    always_comb begin
        w_frame = 3'd0;
        case (r_state)
            ST_FLY:  w_frame = r_anim_frame;
            ST_HIT:  w_frame = 3'(FRAME_HIT);
            ST_FALL: w_frame = 3'(FRAME_FALL);
            default: w_frame = 3'd0;
        endcase
    end

`ifdef DUCK_MIRROR_EN
    assign w_col = (dir_left && (r_state == ST_FLY)) ? (6'(SPR_W - 1) - w_rx[5:0]) : w_rx[5:0];
`else
    logic w_unused_dir;
    assign w_unused_dir = dir_left;
    assign w_col        = w_rx[5:0];
`endif

    assign w_addr = w_inbox ? (ROM_AW'(w_frame) * ROM_AW'(SPR_W * SPR_H)
                               + ROM_AW'(w_ry[5:0]) * ROM_AW'(SPR_W)
                               + ROM_AW'(w_col))
                            : '0;

    // Stage 1: ROM read with the box flag riding alongside.
    logic [3:0] w_rom_q;
    logic       r_inbox_d;

    duck_sprite_rom u_rom (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_addr (w_addr),
        .o_q    (w_rom_q)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_inbox_d <= 1'b0;
        end else begin
            r_inbox_d <= w_inbox;
        end
    end

    // Stage 2: index 0 is the transparent key.
    logic [3:0] r_index;
    logic       r_sprite_on;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_index     <= 4'd0;
            r_sprite_on <= 1'b0;
        end else begin
            r_index     <= r_inbox_d ? w_rom_q : 4'd0;
            r_sprite_on <= r_inbox_d && (w_rom_q != 4'd0);
        end
    end

    assign index      = r_index;
    assign sprite_on  = r_sprite_on;
    assign duck_state = r_state;
    assign duck_done  = r_done;

endmodule

// File: tb/tb_duck_sprite_indexer.sv
// Bench for duck_sprite_indexer: randomized pixels against an event-count reference model.
module tb_duck_sprite_indexer;

    localparam int SPR_W      = 44;
    localparam int SPR_H      = 44;
    localparam int N_FLY      = 3;
    localparam int ANIM_DIV   = 8;
    localparam int HIT_FRAMES = 30;
    localparam int FALL_STEP  = 2;
    localparam int SCREEN_H   = 480;

    logic       Clk = 1'b0;
    logic       Reset, frame_start, spawn, shot, dir_left;
    logic [9:0] DrawX, DrawY, DuckX, DuckY;
    logic [3:0] index;
    logic       sprite_on, duck_done;
    logic [1:0] duck_state;

    always #5 Clk = ~Clk;

    duck_sprite_indexer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .DuckX       (DuckX),
        .DuckY       (DuckY),
        .spawn       (spawn),
        .shot        (shot),
        .dir_left    (dir_left),
        .index       (index),
        .sprite_on   (sprite_on),
        .duck_state  (duck_state),
        .duck_done   (duck_done)
    );

    // Model: state 0..3 plus frame_start counts since spawn / shot / start of fall.
    int m_st, n_fly, n_hit, n_fall;
    int p1_idx, p1_on, p2_idx, p2_on, exp_done;
    int n_total, n_pass, n_fail;

    function automatic int sheet(input int a);
        return (a & 15) ^ ((a >> 4) & 15) ^ ((a >> 8) & 15) ^ ((a >> 12) & 3);
    endfunction

    function automatic int duck_top();
        return int'(DuckY) + ((m_st == 3) ? FALL_STEP * n_fall : 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        int rx, ry, ytop, fr, col, idx, on, inb, done_now;
        if (Reset) begin
            m_st = 0; n_fly = 0; n_hit = 0; n_fall = 0;
            p1_idx = 0; p1_on = 0; p2_idx = 0; p2_on = 0; exp_done = 0;
        end else begin
            ytop = duck_top();
            rx   = int'(DrawX) - int'(DuckX);
            ry   = int'(DrawY) - ytop;
            inb  = (m_st != 0 && rx >= 0 && rx < SPR_W && ry >= 0 && ry < SPR_H) ? 1 : 0;
            fr   = (m_st == 1) ? (n_fly / ANIM_DIV) % N_FLY : (m_st == 2) ? N_FLY : N_FLY + 1;
            col  = rx;
`ifdef DUCK_MIRROR_EN
            if (m_st == 1 && dir_left) col = SPR_W - 1 - rx;
`endif
            idx  = inb ? sheet(fr * SPR_W * SPR_H + ry * SPR_W + col) : 0;
            on   = (inb && idx != 0) ? 1 : 0;
            p2_idx = p1_idx; p2_on = p1_on;
            p1_idx = idx;    p1_on = on;
            done_now = (m_st == 3 && ytop >= SCREEN_H) ? 1 : 0;
            exp_done = done_now;
            case (m_st)
                0: if (spawn) begin m_st = 1; n_fly = 0; end
                1: if (shot) begin m_st = 2; n_hit = 0; end
                   else if (frame_start) n_fly++;
                2: if (frame_start) begin
                       n_hit++;
                       if (n_hit == HIT_FRAMES) begin m_st = 3; n_fall = 0; end
                   end
                default: if (done_now) m_st = 0;
                         else if (frame_start) n_fall++;
            endcase
        end
        @(posedge Clk);
        #1;
        check("index", 32'(index), 32'(p2_idx));
        check("sprite_on", 32'(sprite_on), 32'(p2_on));
        check("duck_state", 32'(duck_state), 32'(m_st));
        check("duck_done", 32'(duck_done), 32'(exp_done));
    endtask

    task automatic rand_pix();
        DrawX = 10'(int'(DuckX) + int'($urandom_range(0, 52)) - 4);
        DrawY = 10'(duck_top() + int'($urandom_range(0, 52)) - 4);
    endtask

    task automatic pulse_fs(input int extra);
        frame_start = 1'b1; rand_pix(); step();
        frame_start = 1'b0;
        repeat (extra) begin rand_pix(); step(); end
    endtask

    initial begin
        Reset = 1'b1; frame_start = 1'b0; spawn = 1'b0; shot = 1'b0; dir_left = 1'b0;
        DrawX = '0; DrawY = '0; DuckX = '0; DuckY = '0;
        n_total = 0; n_pass = 0; n_fail = 0;
        m_st = 0; n_fly = 0; n_hit = 0; n_fall = 0;
        p1_idx = 0; p1_on = 0; p2_idx = 0; p2_on = 0; exp_done = 0;
        #2;
        step(); step();
        Reset = 1'b0;
        repeat (3) begin rand_pix(); step(); end

        shot = 1'b1; step(); shot = 1'b0;

        DuckX = 10'd100; DuckY = 10'd50;
        spawn = 1'b1; step(); spawn = 1'b0;

        DrawY = 10'd60;
        for (int x = 98; x <= 146; x++) begin
            DrawX = 10'(x);
            step();
        end
        step(); step();

        for (int f = 0; f < 24; f++) begin
            dir_left = 1'($urandom_range(0, 1));
            pulse_fs(4);
        end

        // Reset with in-box pixels still in the pipeline.
        DrawX = 10'd110; DrawY = 10'd60; step();
        DrawX = 10'd120; step();
        Reset = 1'b1; step();
        Reset = 1'b0; step(); step();

        spawn = 1'b1; shot = 1'b1; step(); spawn = 1'b0; shot = 1'b0;
        repeat (5) pulse_fs(2);

        DuckX = 10'd300; DuckY = 10'd400; dir_left = 1'b1;
        rand_pix(); step();
        shot = 1'b1; rand_pix(); step(); shot = 1'b0;
        DrawX = DuckX; DrawY = DuckY; step(); step(); step();
        for (int f = 0; f < HIT_FRAMES; f++) pulse_fs(2);

        spawn = 1'b1; rand_pix(); step(); spawn = 1'b0;
        for (int f = 0; f < 45; f++) pulse_fs(2);
        repeat (4) begin rand_pix(); step(); end

        for (int i = 0; i < 800; i++) begin
            spawn       = ($urandom_range(0, 39) == 0);
            shot        = ($urandom_range(0, 29) == 0);
            frame_start = ($urandom_range(0, 3) == 0);
            dir_left    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) DuckX = 10'($urandom_range(560, 639));
            if ($urandom_range(0, 49) == 0) DuckY = 10'($urandom_range(0, 470));
            rand_pix();
            step();
        end
        spawn = 1'b0; shot = 1'b0; frame_start = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
